hazard_scoreboard: RTL
======================

# hazard_scoreboard

Parametrised hazard scoreboard for the decode stage of the pipelined MIPS core. It tracks in-flight register producers as a shift queue of (destination, remaining-cycles) entries and compares them against the decoding instruction's source registers and their `tuse` values. From that it raises `stall` and reports a forwarding source per operand. Pipeline depth, source count and `tnew`/`tuse` width are parameters, and it adds flush, downstream freeze and a stall-performance counter.

## Interface
- `NSRC`, default 2: number of source operands checked per instruction (rs, rt, …).
- `DEPTH`, default 3: producer stages after D (E, M, W).
- `TW`, default 4: width of `tnew`/`tuse`. The all-ones value means "operand unused".
- `SELW`, default `$clog2(DEPTH+1)`: forward-select width.
- `clk`  in  1: clock. Single clock domain.
- `reset`  in  1: synchronous, active-high.
- `issue_valid`  in  1: D-stage instruction is real (not a bubble).
- `issue_dst`  in  5: destination register of the D instruction.
- `issue_tnew`  in  TW: cycles from D until the result exists (0 = no result).
- `src_addr`  in  NSRC*5: packed source registers, operand 0 in the LSBs.
- `src_tuse`  in  NSRC*TW: packed `tuse` per operand.
- `ext_hold`  in  1: external stall request (mult/div busy).
- `advance`  in  1: downstream pipeline moves this cycle. 0 means a global freeze.
- `flush`  in  1: exception or eret flush.
- `stall`  out  1: hold PC and the D register, and inject a bubble into E.
- `fwd_sel`  out  NSRC*SELW: per operand, 0 = GRF, k = stage k (1 = E … DEPTH = W).
- `stall_cnt`  out  32: saturating count of stalled cycles.

## Operation
**Queue**
- `DEPTH` entries, each {valid, dst[4:0], rem[TW-1:0]}. Entry 1 is E and entry DEPTH is W.

**Matching**
- Operand i matches entry k when all of the following hold: entry valid, dst == `src_addr[i]`, `src_addr[i]` != 0, and `src_tuse[i]` != all-ones.
- Youngest-wins: the lowest k among matching entries decides. Older matches are ignored.

**Stall**
- `stall` = `ext_hold` OR any operand whose youngest match has rem > `src_tuse[i]`.
- Combinational from current queue contents and inputs.

**Forward select**
- `fwd_sel[i]` = k of the youngest match, else 0.
- Valid even when `stall` = 1, because the consumer re-evaluates every cycle.

**Queue update on the clk edge, by priority**
1. `reset` or `flush`: all entries become invalid.
2. `advance` = 0: queue holds unchanged and `stall_cnt` holds.
3. Otherwise:
   - Entry k+1 takes entry k, with rem = sat0(rem-1). Entry DEPTH is dropped.
   - Entry 1 takes {`issue_valid` & !`stall` & `issue_dst` != 0 & `issue_tnew` != 0, `issue_dst`, sat0(`issue_tnew`-1)}.
   - When stalled, entry 1 becomes invalid (bubble).

**Stall counter**
- `stall_cnt` increments when `advance` & `stall` & !`flush`.
- Saturates at 0xFFFF_FFFF and clears only on `reset`.

**Arithmetic**
- All rem/tuse comparisons are unsigned TW-bit.
- sat0 never wraps below 0.

## Timing
- Reset values: all entries invalid, `stall_cnt` = 0.
- Outputs out of reset: `stall` = `ext_hold`, `fwd_sel` = 0.
- `stall`/`fwd_sel` have zero-cycle latency from inputs. The queue has one-cycle latency.
- lw (`tnew` 3) followed by a dependent ALU op (`tuse` 1) gives exactly one stall cycle.
- An ALU op (`tnew` 2) followed by a dependent ALU op gives no stall, with `fwd_sel` = 1.
- Simultaneous `flush` with `stall` or `advance`: flush wins, the queue is empty next cycle and the counter does not increment.
- Reset mid-stall: `stall` drops the cycle after reset (if `ext_hold` = 0).
- A freeze (`advance` = 0) preserves `stall` and `fwd_sel` unchanged across frozen cycles.

## Structure
- Shared package `hazard_pkg` holds:
  - `sb_entry_t` (valid, dst, rem)
  - constant `TUSE_NONE` (all-ones)
  - constant `REG_ZERO`
  - the sat0 decrement function
- Sub-module `sb_src_match`, one instance per operand: youngest-match priority encoder producing the {hit, k, rem} outputs.
- The top holds the queue, the stall OR-reduction and the counter.

## Test plan
- lw $1 (`tnew` 3), then add $2,$1,$3 (`tuse` 1) -> `stall` = 1 for 1 cycle. Next cycle `fwd_sel[0]` = 2, then the add issues.
- addu $1 (`tnew` 2), then beq $1,$4 (`tuse` 0) -> 1 stall cycle. Next cycle `fwd_sel[0]` = 2 and `stall` = 0.
- ori $0,… (dst 0), then use $0 -> never stalls, `fwd_sel` = 0. A source with `tuse` = 0xF never stalls.
- Two writers to $5 in E and M (E rem 0, M rem 0) -> `fwd_sel` = 1 (youngest wins). With `advance` = 0 for 3 cycles, outputs are identical throughout.
- Stall pending and `flush` asserted -> queue empty next cycle, `stall` = 0, `stall_cnt` unchanged that cycle.
- Force `stall_cnt` to 0xFFFF_FFFE, then 3 stalled advancing cycles -> counter holds at 0xFFFF_FFFF. `reset` -> 0.

Source files
------------

// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types, constants and helpers for the decode-stage hazard scoreboard
package hazard_pkg;
  // rem is stored at a fixed maximum width so the entry type needs no parameter
  localparam int REM_W = 16;
  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam logic [REM_W-1:0] TUSE_NONE = '1;
  typedef struct packed {
    logic valid;
    logic [4:0] dst;
    logic [REM_W-1:0] rem;
  } sb_entry_t;
  function automatic logic [REM_W-1:0] sat0(input logic [REM_W-1:0] v);
    return (v == '0) ? v : v - REM_W'(1);
  endfunction
endpackage

// File: rtl/sb_src_match.sv
// sb_src_match: youngest-match priority encoder of one source operand against the producer queue
module sb_src_match
  import hazard_pkg::*;
#(
  parameter int DEPTH = 3,
  parameter int TW = 4,
  parameter int SELW = $clog2(DEPTH + 1)
) (
  input  sb_entry_t [DEPTH-1:0] q,
  input  logic [4:0]            src,
  input  logic [TW-1:0]         tuse,
  output logic                  hit,
  output logic [SELW-1:0]       k,
  output logic [REM_W-1:0]      rem
);
  logic use_op;
  assign use_op = (src != REG_ZERO) && (tuse != TUSE_NONE[TW-1:0]);
  // Scan oldest to youngest so the lowest matching stage overrides the rest
  always_comb begin
    hit = 1'b0;
    k = '0;
    rem = '0;
    for (int j = DEPTH - 1; j >= 0; j--) begin
      if (use_op && q[j].valid && q[j].dst == src) begin
        hit = 1'b1;
        k = SELW'(j + 1);
        rem = q[j].rem;
      end
    end
  end
endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: decode-stage producer queue raising stall and per-operand forward selects
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int NSRC = 2,
  parameter int DEPTH = 3,
  parameter int TW = 4,
  parameter int SELW = $clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 issue_valid,
  input  logic [4:0]           issue_dst,
  input  logic [TW-1:0]        issue_tnew,
  input  logic [NSRC*5-1:0]    src_addr,
  input  logic [NSRC*TW-1:0]   src_tuse,
  input  logic                 ext_hold,
  input  logic                 advance,
  input  logic                 flush,
  output logic                 stall,
  output logic [NSRC*SELW-1:0] fwd_sel,
  output logic [31:0]          stall_cnt
);
  sb_entry_t [DEPTH-1:0] q;
  logic [NSRC-1:0] op_stall;
  for (genvar i = 0; i < NSRC; i++) begin : g_src
    logic hit;
    logic [REM_W-1:0] rem;
    sb_src_match #(.DEPTH(DEPTH), .TW(TW), .SELW(SELW)) u_match (
      .q(q),
      .src(src_addr[i*5 +: 5]),
      .tuse(src_tuse[i*TW +: TW]),
      .hit(hit),
      .k(fwd_sel[i*SELW +: SELW]),
      .rem(rem)
    );
    assign op_stall[i] = hit && (rem > REM_W'(src_tuse[i*TW +: TW]));
  end
  assign stall = ext_hold || (|op_stall);
  always_ff @(posedge clk) begin
    if (reset || flush) q <= '0;
    else if (advance) begin
      for (int j = DEPTH - 1; j > 0; j--)
        q[j] <= '{valid: q[j-1].valid, dst: q[j-1].dst, rem: sat0(q[j-1].rem)};
      q[0] <= '{valid: issue_valid && !stall && issue_dst != REG_ZERO && issue_tnew != '0,
                dst: issue_dst, rem: sat0(REM_W'(issue_tnew))};
    end
    if (reset) stall_cnt <= '0;
    else if (advance && stall && !flush && stall_cnt != '1) stall_cnt <= stall_cnt + 32'd1;
  end
endmodule
